tdo_mux: RTL and testbench
==========================

Name: tdo_mux

Overview:
- Transmit-side counterpart of the per-bit TDI compare path in the executor.
- Accepts drive bytes from the executor over a valid/ready handshake and double-buffers them (holding register plus shift register).
- Serialises each byte onto TDO LSB-first, one bit per shift strobe.
- Publishes the current bit address so the receive-side compare logic stays bit-aligned. Supports a partial final byte and reports underrun.

Parameters:
- DW, 8, drive byte width in bits.
- AW, 3, bit address width; must equal log2(DW).

Ports:
- clk  input  1  system clock; all state changes on its rising edge.
- reset  input  1  asynchronous, active-high reset.
- drv  input  DW  drive byte; bit 0 is shifted out first.
- drv_last  input  1  qualifies drv as the final byte of the scan.
- drv_bits  input  AW  index of the last valid bit in the final byte; ignored unless drv_last=1.
- drv_valid  input  1  drv, drv_last and drv_bits are valid.
- drv_ready  output  1  holding register empty; transfer occurs when drv_valid&drv_ready at a clk edge.
- shift  input  1  one-clk strobe from TCK edge logic; advances one bit.
- tdo  output  1  serial test data out.
- tdo_en  output  1  TDO driver enable.
- adr  output  AW  index of the bit currently presented on tdo.
- byte_done  output  1  one-clk pulse when the last bit of a byte is shifted.
- scan_done  output  1  one-clk pulse when the last bit of the drv_last byte is shifted.
- underrun  output  1  sticky: shift arrived while no data was available mid-scan.

Behaviour:
- Reset (async, immediate):
  - state=IDLE, holding empty, drv_ready=1.
  - tdo=0, tdo_en=0, adr=0.
  - byte_done=0, scan_done=0, underrun=0.
- Holding register:
  - Captures drv/drv_last/drv_bits on an accepted transfer.
  - drv_ready = !hold_full (combinational from the flag).
- Shift register:
  - tdo = sh[0] whenever tdo_en=1; tdo=0 in IDLE.
  - Per-byte end index: end = drv_bits if the byte's last flag is set, else DW-1.
- IDLE:
  - tdo_en=0. shift is ignored and does not set underrun.
  - On an edge with hold_full: load sh from holding, adr=0, hold_full cleared, go to ACTIVE.
  - Latency: byte accepted at edge N, first bit on tdo after edge N+1.
  - Accepting a transfer in IDLE clears underrun.
- ACTIVE (tdo_en=1):
  - shift with adr!=end: sh>>=1, adr+=1.
  - shift with adr==end: byte_done=1 for one clk, then:
    - byte was last: scan_done=1, go to IDLE, adr=0.
    - else if hold_full: reload sh from holding, adr=0, stay ACTIVE.
    - else if drv_valid&drv_ready on the same edge (bypass): load sh directly from drv, adr=0, stay ACTIVE; holding stays empty.
    - else: go to STALL.
- STALL:
  - tdo_en=1; tdo and adr hold the final bit of the previous byte.
  - shift sets underrun=1 and is otherwise ignored (no bit consumed).
  - Edge with hold_full: reload sh, adr=0, go to ACTIVE.
  - Edge with drv_valid&drv_ready: bypass load directly into sh, go to ACTIVE.
- No shift strobe: state, adr and tdo hold indefinitely.
- adr never exceeds end; it never wraps past DW-1.
- The holding register accepts a new byte in any state, including while the shift register is busy.
- Reset asserted mid-scan: all outputs return to reset values asynchronously; the partial byte is discarded.
- drv_last with drv_bits=0: exactly one bit is shifted; byte_done and scan_done pulse together on that shift.

Test Plan:
- Single byte 0xA5 with drv_last=1, drv_bits=7, then 8 shift strobes -> tdo sequence 1,0,1,0,0,1,0,1; adr 0..7; byte_done and scan_done pulse on the 8th strobe; tdo_en=0 the next clk.
- Two bytes 0x0F then 0xF0 (last), second accepted while the first is shifting, 16 strobes -> continuous stream 1111000000001111; no STALL; underrun=0.
- Byte 0x3C not last, then 8 strobes and 2 extra strobes before the next byte arrives -> STALL entered; tdo holds 0; underrun=1 stays set; next byte 0x01 (last, drv_bits=0) accepted -> one strobe gives tdo=1 with scan_done.
- Bypass: drv_valid asserted on the same clk as the 8th strobe of a non-last byte -> next byte's bit 0 on tdo the following clk; holding stays empty; drv_ready=1.
- Partial final byte 0xFF with drv_bits=2 -> exactly 3 bits shifted, scan_done on the 3rd strobe; extra strobes in IDLE leave underrun=0.
- reset pulsed at adr=4 mid-byte -> tdo_en=0, adr=0, drv_ready=1 immediately; a fresh byte afterwards starts at adr=0.

Source files
------------

// File: rtl/tdo_mux.sv
// tdo_mux: double-buffered LSB-first TDO serialiser.
// Publishes bit address, byte/scan done pulses and sticky underrun.
module tdo_mux #(
  parameter int DW = 8,
  parameter int AW = 3
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [DW-1:0] drv,
  input  logic          drv_last,
  input  logic [AW-1:0] drv_bits,
  input  logic          drv_valid,
  output logic          drv_ready,
  input  logic          shift,
  output logic          tdo,
  output logic          tdo_en,
  output logic [AW-1:0] adr,
  output logic          byte_done,
  output logic          scan_done,
  output logic          underrun
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACTIVE = 2'd1,
    STALL  = 2'd2
  } state_e;

  localparam logic [AW-1:0] FULL_END = AW'(DW - 1);

  state_e        state_q, state_d;
  logic [DW-1:0] hold_q, hold_d;
  logic          hold_last_q, hold_last_d;
  logic [AW-1:0] hold_bits_q, hold_bits_d;
  logic          hold_full_q, hold_full_d;
  logic [DW-1:0] sh_q, sh_d;
  logic          sh_last_q, sh_last_d;
  logic [AW-1:0] sh_end_q, sh_end_d;
  logic [AW-1:0] adr_q, adr_d;
  logic          byte_done_q, byte_done_d;
  logic          scan_done_q, scan_done_d;
  logic          underrun_q, underrun_d;

  logic accept;
  logic load_hold;
  logic bypass;

  function automatic logic [AW-1:0] end_of(
    input logic          last,
    input logic [AW-1:0] bits
  );
    return last ? bits : FULL_END;
  endfunction

  assign accept    = drv_valid & ~hold_full_q;
  assign drv_ready = ~hold_full_q;
  assign tdo_en    = (state_q != IDLE);
  assign tdo       = tdo_en & sh_q[0];
  assign adr       = adr_q;
  assign byte_done = byte_done_q;
  assign scan_done = scan_done_q;
  assign underrun  = underrun_q;

  // Next-state: sequencing, shift register moves and holding register fill.
  always_comb begin
    state_d     = state_q;
    hold_d      = hold_q;
    hold_last_d = hold_last_q;
    hold_bits_d = hold_bits_q;
    hold_full_d = hold_full_q;
    sh_d        = sh_q;
    sh_last_d   = sh_last_q;
    sh_end_d    = sh_end_q;
    adr_d       = adr_q;
    byte_done_d = 1'b0;
    scan_done_d = 1'b0;
    underrun_d  = underrun_q;
    load_hold   = 1'b0;
    bypass      = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (hold_full_q) begin
          load_hold = 1'b1;
          state_d   = ACTIVE;
        end else if (accept) begin
          underrun_d = 1'b0;
        end
      end
      ACTIVE: begin
        if (shift) begin
          if (adr_q != sh_end_q) begin
            sh_d  = sh_q >> 1;
            adr_d = adr_q + AW'(1);
          end else begin
            byte_done_d = 1'b1;
            if (sh_last_q) begin
              scan_done_d = 1'b1;
              state_d     = IDLE;
              adr_d       = '0;
            end else if (hold_full_q) begin
              load_hold = 1'b1;
            end else if (accept) begin
              bypass = 1'b1;
            end else begin
              state_d = STALL;
            end
          end
        end
      end
      STALL: begin
        if (shift) begin
          underrun_d = 1'b1;
        end
        if (hold_full_q) begin
          load_hold = 1'b1;
          state_d   = ACTIVE;
        end else if (accept) begin
          bypass  = 1'b1;
          state_d = ACTIVE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Holding register drains into the shifter.
    if (load_hold) begin
      sh_d        = hold_q;
      sh_last_d   = hold_last_q;
      sh_end_d    = end_of(hold_last_q, hold_bits_q);
      adr_d       = '0;
      hold_full_d = 1'b0;
    end

    // Bypass skips the holding register entirely.
    if (bypass) begin
      sh_d      = drv;
      sh_last_d = drv_last;
      sh_end_d  = end_of(drv_last, drv_bits);
      adr_d     = '0;
    end

    if (accept && !bypass) begin
      hold_d      = drv;
      hold_last_d = drv_last;
      hold_bits_d = drv_bits;
      hold_full_d = 1'b1;
    end
  end

  // State and datapath registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      hold_q      <= '0;
      hold_last_q <= 1'b0;
      hold_bits_q <= '0;
      hold_full_q <= 1'b0;
      sh_q        <= '0;
      sh_last_q   <= 1'b0;
      sh_end_q    <= '0;
      adr_q       <= '0;
      byte_done_q <= 1'b0;
      scan_done_q <= 1'b0;
      underrun_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      hold_q      <= hold_d;
      hold_last_q <= hold_last_d;
      hold_bits_q <= hold_bits_d;
      hold_full_q <= hold_full_d;
      sh_q        <= sh_d;
      sh_last_q   <= sh_last_d;
      sh_end_q    <= sh_end_d;
      adr_q       <= adr_d;
      byte_done_q <= byte_done_d;
      scan_done_q <= scan_done_d;
      underrun_q  <= underrun_d;
    end
  end

endmodule

// File: tb/tb_tdo_mux.sv
// tb_tdo_mux: directed vectors against a byte/position reference model
// plus literal expectations for the serial stream.
module tb_tdo_mux;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] drv = '0;
  logic       drv_last = 1'b0;
  logic [2:0] drv_bits = '0;
  logic       drv_valid = 1'b0;
  logic       drv_ready;
  logic       shift = 1'b0;
  logic       tdo;
  logic       tdo_en;
  logic [2:0] adr;
  logic       byte_done;
  logic       scan_done;
  logic       underrun;

  int n_cmp = 0;
  int n_bad = 0;
  logic run_cmp = 1'b0;

  tdo_mux #(.DW(8), .AW(3)) dut (
    .clk(clk), .reset(reset),
    .drv(drv), .drv_last(drv_last),
    .drv_bits(drv_bits), .drv_valid(drv_valid),
    .drv_ready(drv_ready), .shift(shift),
    .tdo(tdo), .tdo_en(tdo_en), .adr(adr),
    .byte_done(byte_done), .scan_done(scan_done),
    .underrun(underrun)
  );

  always #5 clk = ~clk;

  // Reference model: current byte + bit position, one holding slot.
  // m_st: 0 idle, 1 shifting, 2 waiting for data.
  int         m_st = 0;
  logic [7:0] m_cur = '0;
  logic       m_last = 1'b0;
  int         m_end = 0;
  int         m_pos = 0;
  logic       h_full = 1'b0;
  logic [7:0] h_byte = '0;
  logic       h_last = 1'b0;
  int         h_bits = 0;
  logic       m_bd = 1'b0;
  logic       m_sd = 1'b0;
  logic       m_ur = 1'b0;
  logic       acc, byp;

  task automatic m_take_hold();
    m_cur  = h_byte;
    m_last = h_last;
    m_end  = h_last ? h_bits : 7;
    m_pos  = 0;
    h_full = 1'b0;
    m_st   = 1;
  endtask

  task automatic m_take_drv();
    m_cur  = drv;
    m_last = drv_last;
    m_end  = drv_last ? int'(drv_bits) : 7;
    m_pos  = 0;
    m_st   = 1;
    byp    = 1'b1;
  endtask

  initial forever begin
    @(posedge clk or posedge reset);
    if (reset) begin
      m_st = 0; m_pos = 0; h_full = 1'b0;
      m_bd = 1'b0; m_sd = 1'b0; m_ur = 1'b0;
    end else begin
      acc  = drv_valid && !h_full;
      byp  = 1'b0;
      m_bd = 1'b0;
      m_sd = 1'b0;
      if (m_st == 0) begin
        if (h_full) m_take_hold();
        else if (acc) m_ur = 1'b0;
      end else if (m_st == 1) begin
        if (shift) begin
          if (m_pos < m_end) m_pos++;
          else begin
            m_bd = 1'b1;
            if (m_last) begin
              m_sd = 1'b1; m_st = 0; m_pos = 0;
            end else if (h_full) m_take_hold();
            else if (acc) m_take_drv();
            else m_st = 2;
          end
        end
      end else begin
        if (shift) m_ur = 1'b1;
        if (h_full) m_take_hold();
        else if (acc) m_take_drv();
      end
      if (acc && !byp) begin
        h_byte = drv; h_last = drv_last;
        h_bits = int'(drv_bits); h_full = 1'b1;
      end
    end
  end

  task automatic chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Model comparison on every falling edge.
  always @(negedge clk) begin
    if (run_cmp) begin
      chk("m_tdo_en", int'(tdo_en), (m_st != 0) ? 1 : 0);
      chk("m_tdo", int'(tdo),
          (m_st != 0) ? int'(m_cur[m_pos[2:0]]) : 0);
      chk("m_adr", int'(adr), m_pos);
      chk("m_ready", int'(drv_ready), h_full ? 0 : 1);
      chk("m_byte_done", int'(byte_done), int'(m_bd));
      chk("m_scan_done", int'(scan_done), int'(m_sd));
      chk("m_underrun", int'(underrun), int'(m_ur));
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] b, input logic l,
                      input logic [2:0] nb);
    int k;
    k = 0;
    while (!drv_ready && k < 50) begin
      cyc();
      k++;
    end
    chk("send_ready", int'(drv_ready), 1);
    drv = b; drv_last = l; drv_bits = nb; drv_valid = 1'b1;
    cyc();
    drv_valid = 1'b0;
  endtask

  task automatic strobe();
    shift = 1'b1;
    cyc();
    shift = 1'b0;
  endtask

  logic [7:0]  s1 = 8'b10100101;
  logic [15:0] s2 = 16'b1111000000001111;
  logic [7:0]  s3 = 8'b00111100;

  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk("rst_tdo", int'(tdo), 0);
    chk("rst_tdo_en", int'(tdo_en), 0);
    chk("rst_adr", int'(adr), 0);
    chk("rst_ready", int'(drv_ready), 1);
    chk("rst_underrun", int'(underrun), 0);
    reset = 1'b0;
    run_cmp = 1'b1;
    cyc();

    // single full byte 0xA5
    send(8'hA5, 1'b1, 3'd7);
    chk("t1_not_yet", int'(tdo_en), 0);
    cyc();
    for (int i = 0; i < 8; i++) begin
      chk("t1_tdo", int'(tdo), int'(s1[7-i]));
      chk("t1_adr", int'(adr), i);
      strobe();
    end
    chk("t1_byte_done", int'(byte_done), 1);
    chk("t1_scan_done", int'(scan_done), 1);
    chk("t1_tdo_en_off", int'(tdo_en), 0);
    cyc();

    // two bytes back to back, second accepted mid-shift
    send(8'h0F, 1'b0, 3'd0);
    cyc();
    shift = 1'b1;
    for (int i = 0; i < 16; i++) begin
      chk("t2_tdo", int'(tdo), int'(s2[15-i]));
      chk("t2_no_stall", int'(tdo_en), 1);
      if (i == 1) begin
        drv = 8'hF0; drv_last = 1'b1; drv_bits = 3'd7;
        drv_valid = 1'b1;
      end
      cyc();
      drv_valid = 1'b0;
    end
    shift = 1'b0;
    chk("t2_scan_done", int'(scan_done), 1);
    chk("t2_underrun", int'(underrun), 0);
    cyc();

    // stall and underrun, then single-bit final byte
    send(8'h3C, 1'b0, 3'd0);
    cyc();
    for (int i = 0; i < 8; i++) begin
      chk("t3_tdo", int'(tdo), int'(s3[7-i]));
      strobe();
    end
    chk("t3_stall_en", int'(tdo_en), 1);
    chk("t3_stall_tdo", int'(tdo), 0);
    chk("t3_stall_adr", int'(adr), 7);
    strobe();
    strobe();
    chk("t3_underrun", int'(underrun), 1);
    chk("t3_hold_adr", int'(adr), 7);
    send(8'h01, 1'b1, 3'd0);
    chk("t3_bit0", int'(tdo), 1);
    chk("t3_adr0", int'(adr), 0);
    strobe();
    chk("t3_byte_done", int'(byte_done), 1);
    chk("t3_scan_done", int'(scan_done), 1);
    chk("t3_sticky", int'(underrun), 1);
    cyc();

    // bypass on the final strobe of a non-last byte
    send(8'h01, 1'b0, 3'd0);
    chk("t4_ur_clear", int'(underrun), 0);
    cyc();
    for (int i = 0; i < 7; i++) strobe();
    shift = 1'b1;
    drv = 8'h03; drv_last = 1'b1; drv_bits = 3'd7;
    drv_valid = 1'b1;
    cyc();
    shift = 1'b0;
    drv_valid = 1'b0;
    chk("t4_bypass_tdo", int'(tdo), 1);
    chk("t4_bypass_adr", int'(adr), 0);
    chk("t4_ready", int'(drv_ready), 1);
    chk("t4_byte_done", int'(byte_done), 1);
    for (int i = 0; i < 8; i++) strobe();
    chk("t4_scan_done", int'(scan_done), 1);
    cyc();

    // partial final byte, extra strobes in idle
    send(8'hFF, 1'b1, 3'd2);
    cyc();
    strobe();
    strobe();
    chk("t5_adr2", int'(adr), 2);
    strobe();
    chk("t5_scan_done", int'(scan_done), 1);
    chk("t5_idle", int'(tdo_en), 0);
    for (int i = 0; i < 3; i++) strobe();
    chk("t5_underrun", int'(underrun), 0);
    chk("t5_adr_idle", int'(adr), 0);

    // asynchronous reset mid-byte with a byte held
    send(8'hAA, 1'b1, 3'd7);
    cyc();
    for (int i = 0; i < 4; i++) strobe();
    chk("t6_adr4", int'(adr), 4);
    send(8'h55, 1'b1, 3'd7);
    chk("t6_full", int'(drv_ready), 0);
    #2;
    reset = 1'b1;
    #1;
    chk("t6_rst_en", int'(tdo_en), 0);
    chk("t6_rst_adr", int'(adr), 0);
    chk("t6_rst_ready", int'(drv_ready), 1);
    chk("t6_rst_tdo", int'(tdo), 0);
    cyc();
    reset = 1'b0;
    cyc();
    send(8'h5A, 1'b1, 3'd7);
    cyc();
    chk("t6_fresh_adr", int'(adr), 0);
    chk("t6_fresh_tdo", int'(tdo), 0);
    strobe();
    chk("t6_fresh_bit1", int'(tdo), 1);
    for (int i = 0; i < 7; i++) strobe();
    chk("t6_scan_done", int'(scan_done), 1);
    cyc();
    cyc();

    run_cmp = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
